// File: rtl/scan_sequencer_pkg.sv
// Shared types and default timing for the digit scan sequencer.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BLK  = 2'd1,
        SHOW = 2'd2
    } state_t;

    typedef logic [2:0] idx_t;

    localparam int DIV_DEF   = 50000;
    localparam int BLANK_DEF = 16;
    localparam int NDIG_DEF  = 8;

endpackage

// File: rtl/scan_sequencer_if.sv
// Control inputs and decoder-facing outputs of the scan sequencer.
interface scan_sequencer_if;
    import scan_pkg::*;

    logic en;
    logic mode;
    logic dir;
    logic step;
    logic A;
    logic B;
    logic C;
    idx_t idx;
    logic blank;
    logic frame;

    modport master (
        output en, mode, dir, step,
        input  A, B, C, idx, blank, frame
    );

    modport slave (
        input  en, mode, dir, step,
        output A, B, C, idx, blank, frame
    );

endinterface

// File: rtl/scan_sequencer_slot_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module slot_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    // Saturates at zero so a held slot stops counting until reloaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Multiplexed-display digit scanner: FSM, index register and decoder select encoding.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DIV   = DIV_DEF,
    parameter int BLANK = BLANK_DEF,
    parameter int NDIG  = NDIG_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    scan_sequencer_if.slave  bus
);

    localparam int            CNT_W   = $clog2(DIV);
    localparam logic [CNT_W-1:0] BLK_LD  = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] SHOW_LD = CNT_W'(DIV - BLANK - 1);
    localparam idx_t          LAST    = 3'(NDIG - 1);

    state_t           state;
    state_t           state_n;
    logic [1:0]       rel_q;
    logic             run;
    logic             step_q;
    logic             step_rise;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_tc;
    logic             adv;
    logic [3:0]       adv_res;
    idx_t             idx_q;
    logic [2:0]       abc_q;
    logic             blank_q;
    logic             frame_q;

    // Returns {wrap, next_idx}; an out-of-range index recovers to 0 without a wrap.
    function automatic logic [3:0] advance(input idx_t cur, input logic down);
        if ({1'b0, cur} >= 4'(NDIG)) begin
            return {1'b0, 3'd0};
        end else if (!down) begin
            return (cur == LAST) ? {1'b1, 3'd0} : {1'b0, cur + 3'd1};
        end else begin
            return (cur == 3'd0) ? {1'b1, LAST} : {1'b0, cur - 3'd1};
        end
    endfunction

    // Two-flop release: the FSM stays in IDLE until rst_n has been high for two edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rel_q  <= 2'b00;
            step_q <= 1'b0;
        end else begin
            rel_q  <= {rel_q[0], 1'b1};
            step_q <= bus.step;
        end
    end

    assign run       = bus.en & rel_q[1];
    assign step_rise = bus.step & ~step_q;
    assign adv_res   = advance(idx_q, bus.dir);

    slot_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        tmr_load = 1'b0;
        tmr_val  = BLK_LD;
        adv      = 1'b0;
        if (!run) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n  = BLK;
                    tmr_load = 1'b1;
                end
                BLK: begin
                    if (tmr_tc) begin
                        state_n  = SHOW;
                        tmr_load = 1'b1;
                        tmr_val  = SHOW_LD;
                    end
                end
                SHOW: begin
                    if (bus.mode ? step_rise : tmr_tc) begin
                        adv      = 1'b1;
                        state_n  = BLK;
                        tmr_load = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Index and select code move only on the edge that enters BLK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= 3'd0;
            abc_q   <= 3'b111;
            blank_q <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            blank_q <= (state_n != SHOW);
            frame_q <= adv & adv_res[3];
            if (adv) begin
                idx_q <= adv_res[2:0];
                abc_q <= ~adv_res[2:0];
            end
        end
    end

    assign bus.idx   = idx_q;
    assign bus.A     = abc_q[2];
    assign bus.B     = abc_q[1];
    assign bus.C     = abc_q[0];
    assign bus.blank = blank_q;
    assign bus.frame = frame_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer: two instances (NDIG=8 and NDIG=3), DIV=10, BLANK=2.
module tb_scan_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    scan_sequencer_if ifa();
    scan_sequencer_if ifb();

    scan_sequencer #(.DIV(10), .BLANK(2), .NDIG(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    scan_sequencer #(.DIV(10), .BLANK(2), .NDIG(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    typedef struct {
        logic [2:0] idx;
        int         cyc;
    } show_t;

    show_t show_a[$];
    show_t show_b[$];
    int    frame_a[$];
    int    frame_b[$];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int ref_c  = 0;

    logic       pbl_a  = 1'b1;
    logic       pbl_b  = 1'b1;
    logic [2:0] pidx_a = 3'd0;
    logic [2:0] pidx_b = 3'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_a(input int idx, input int off);
        show_t e;
        e.idx = 3'(idx);
        e.cyc = ref_c + off;
        show_a.push_back(e);
    endtask

    task automatic push_b(input int idx, input int off);
        show_t e;
        e.idx = 3'(idx);
        e.cyc = ref_c + off;
        show_b.push_back(e);
    endtask

    // Pops an expectation whenever a SHOW window opens or a frame pulse appears.
    task automatic mon(input int w, input logic bl, input logic pbl,
                       input logic [2:0] ix, input logic [2:0] pix,
                       input logic [2:0] ab, input logic fr);
        show_t      e;
        int         n;
        int         fc;
        logic [2:0] eab;
        string      s;
        s = (w == 0) ? "a" : "b";
        if (ix != pix) chk({"blank_on_idx_change_", s}, int'(bl), 1);
        if (pbl && !bl) begin
            n = (w == 0) ? show_a.size() : show_b.size();
            chk({"show_expected_", s}, int'(n > 0), 1);
            if (n > 0) begin
                if (w == 0) e = show_a.pop_front();
                else        e = show_b.pop_front();
                eab = ~e.idx;
                chk({"show_idx_", s}, int'(ix), int'(e.idx));
                chk({"show_abc_", s}, int'(ab), int'(eab));
                chk({"show_cycle_", s}, cyc, e.cyc);
            end
        end
        if (fr) begin
            n = (w == 0) ? frame_a.size() : frame_b.size();
            chk({"frame_expected_", s}, int'(n > 0), 1);
            if (n > 0) begin
                if (w == 0) fc = frame_a.pop_front();
                else        fc = frame_b.pop_front();
                chk({"frame_cycle_", s}, cyc, fc);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, ifa.blank, pbl_a, ifa.idx, pidx_a, {ifa.A, ifa.B, ifa.C}, ifa.frame);
        mon(1, ifb.blank, pbl_b, ifb.idx, pidx_b, {ifb.A, ifb.B, ifb.C}, ifb.frame);
        pbl_a  <= ifa.blank;
        pidx_a <= ifa.idx;
        pbl_b  <= ifb.blank;
        pidx_b <= ifb.idx;
    end

    task automatic check_reset_vals();
        chk("rst_blank", int'(ifa.blank), 1);
        chk("rst_idx", int'(ifa.idx), 0);
        chk("rst_abc", int'({ifa.A, ifa.B, ifa.C}), 7);
        chk("rst_frame", int'(ifa.frame), 0);
    endtask

    // Called just after a falling edge; reset asserts mid-cycle, before any rising edge.
    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        ifa.en = 1'b0; ifa.mode = 1'b0; ifa.dir = 1'b0; ifa.step = 1'b0;
        ifb.en = 1'b0; ifb.mode = 1'b0; ifb.dir = 1'b0; ifb.step = 1'b0;
        apply_reset();

        // Auto scan upward: full frame 0..7,0 with one wrap pulse.
        ref_c = cyc;
        for (int k = 0; k < 9; k++) push_a(k % 8, 3 + 10 * k);
        frame_a.push_back(ref_c + 81);
        ifa.en = 1'b1;
        repeat (85) @(negedge clk);
        ifa.en = 1'b0;
        repeat (3) @(negedge clk);

        // Auto scan downward: 0,7,6 with the wrap on 0->7.
        apply_reset();
        ifa.dir = 1'b1;
        ref_c = cyc;
        push_a(0, 3); push_a(7, 13); push_a(6, 23);
        frame_a.push_back(ref_c + 11);
        ifa.en = 1'b1;
        repeat (25) @(negedge clk);
        ifa.en = 1'b0;
        repeat (3) @(negedge clk);

        // en falls exactly on the advance edge: no advance, no frame.
        apply_reset();
        ref_c = cyc;
        push_a(0, 3);
        ifa.en = 1'b1;
        repeat (10) @(negedge clk);
        ifa.en = 1'b0;
        @(negedge clk);
        chk("en_vs_adv_idx", int'(ifa.idx), 0);
        chk("en_vs_adv_frame", int'(ifa.frame), 0);
        chk("en_vs_adv_blank", int'(ifa.blank), 1);
        repeat (3) @(negedge clk);
        ifa.dir = 1'b0;

        // Single-step: step held for 5 cycles gives one advance, then nothing.
        apply_reset();
        ifa.mode = 1'b1;
        ref_c = cyc;
        push_a(0, 3); push_a(1, 9);
        ifa.en = 1'b1;
        repeat (6) @(negedge clk);
        ifa.step = 1'b1;
        repeat (5) @(negedge clk);
        ifa.step = 1'b0;
        repeat (100) @(negedge clk);
        chk("step_hold_idx", int'(ifa.idx), 1);
        chk("step_hold_blank", int'(ifa.blank), 0);
        ifa.en = 1'b0;
        repeat (3) @(negedge clk);
        ifa.mode = 1'b0;

        // en dropped mid-slot, then re-raised: same index comes back after BLANK cycles.
        apply_reset();
        ref_c = cyc;
        push_a(0, 3); push_a(1, 13);
        ifa.en = 1'b1;
        repeat (15) @(negedge clk);
        ifa.en = 1'b0;
        @(negedge clk);
        chk("en_drop_blank", int'(ifa.blank), 1);
        chk("en_drop_idx", int'(ifa.idx), 1);
        chk("en_drop_abc", int'({ifa.A, ifa.B, ifa.C}), 6);
        repeat (3) @(negedge clk);
        ref_c = cyc;
        push_a(1, 3);
        ifa.en = 1'b1;
        repeat (5) @(negedge clk);
        ifa.en = 1'b0;
        repeat (3) @(negedge clk);

        // Reset pulsed mid-SHOW with en held high through the release.
        apply_reset();
        ref_c = cyc;
        push_a(0, 3); push_a(1, 13);
        ifa.en = 1'b1;
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        @(negedge clk);
        ref_c = cyc;
        push_a(0, 5);
        rst_n = 1'b1;
        repeat (7) @(negedge clk);
        ifa.en = 1'b0;
        repeat (3) @(negedge clk);

        // NDIG=3 instance: 0,1,2,0,... with a 30-cycle frame period.
        ref_c = cyc;
        push_b(0, 3);  push_b(1, 13); push_b(2, 23); push_b(0, 33);
        push_b(1, 43); push_b(2, 53); push_b(0, 63);
        frame_b.push_back(ref_c + 31);
        frame_b.push_back(ref_c + 61);
        ifb.en = 1'b1;
        repeat (65) @(negedge clk);
        ifb.en = 1'b0;
        repeat (3) @(negedge clk);

        chk("show_a_left", show_a.size(), 0);
        chk("show_b_left", show_b.size(), 0);
        chk("frame_a_left", frame_a.size(), 0);
        chk("frame_b_left", frame_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter DIV, default 50000: clock cycles per digit slot; legal range 4..2^20.
REQ-002 SHALL have parameter BLANK, default 16: dead cycles at the start of each slot; legal range 1..DIV-2.
REQ-003 SHALL have parameter NDIG, default 8: number of scanned digits; legal range 1..8.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  run enable, level.
REQ-007 SHALL have port mode  input  1  0 = auto scan, 1 = single-step.
REQ-008 SHALL have port dir  input  1  0 = index counts up, 1 = index counts down.
REQ-009 SHALL have port step  input  1  advance request in step mode; acted on at its rising edge only.
REQ-010 SHALL have ports A, B, C  output  1 each  active-low select code for the downstream 3-to-8 decoder: {A,B,C} = ~idx, A is the MSB.
REQ-011 SHALL have port idx  output  3  current digit index, true polarity.
REQ-012 SHALL have port blank  output  1  high = downstream decoder outputs must be gated off.
REQ-013 SHALL have port frame  output  1  one-cycle pulse on every index wrap.

Function
REQ-014 SHALL implement three states: IDLE, BLK, SHOW.
REQ-015 IDLE: blank=1 and idx held; when en=1, SHALL go to BLK on the next edge with the slot counter cleared.
REQ-016 BLK: blank=1 for exactly BLANK cycles, then SHALL go to SHOW.
REQ-017 SHOW, mode=0: blank=0 for exactly DIV-BLANK cycles, then SHALL advance idx and re-enter BLK on the same edge.
REQ-018 SHOW, mode=1: SHALL hold with blank=0 until a step rising edge, then advance idx and enter BLK on the next edge; idle counting SHALL stop.
REQ-019 The step edge detector SHALL be a registered previous-value compare; a step held high SHALL produce exactly one advance.
REQ-020 Advance: dir=0 gives idx+1, and NDIG-1 wraps to 0; dir=1 gives idx-1, and 0 wraps to NDIG-1.
REQ-021 frame SHALL pulse high for one cycle on the edge where a wrap occurs, in either direction.
REQ-022 idx, A, B and C SHALL change only on the edge that enters BLK; they SHALL never change while blank=0.
REQ-023 If idx>=NDIG, which is only reachable through an illegal NDIG change, the next advance SHALL force idx to 0.
REQ-024 en=0 in any state SHALL force IDLE on the next edge with blank=1; idx SHALL be retained and frame SHALL stay 0.
REQ-025 Changes to dir or mode mid-slot SHALL be sampled only at the advance edge.
REQ-026 If en falls on the same edge as an advance, en SHALL win: no advance, no frame pulse.
REQ-027 Latency from en rising to first blank=0 SHALL be 1+BLANK cycles.
REQ-028 In auto mode the slot period SHALL be exactly DIV cycles and the frame period exactly NDIG*DIV cycles.
REQ-029 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-030 While rst_n=0, outputs SHALL take their reset values asynchronously: state=IDLE, idx=0, {A,B,C}=3'b111, blank=1, frame=0, slot counter=0, step history=0.
REQ-031 Reset deassertion SHALL be synchronised internally with a two-flop release; with en=1, the first BLK entry SHALL occur on the edge after the synchroniser releases.
REQ-032 Reset asserted mid-slot SHALL drop any pending advance.

Structure
REQ-033 State encodings (IDLE/BLK/SHOW) and the default DIV/BLANK/NDIG values SHALL live in the shared package scan_pkg.
REQ-034 The slot counter SHALL be one sub-module, slot_timer: a loadable down-counter with a terminal-count flag, reused for both BLK and SHOW durations.
REQ-035 The top level SHALL contain only the FSM, index register and output encoding.

Verification (bench parameters DIV=10, BLANK=2, NDIG=8)
REQ-036 Reset, then en=1, mode=0, dir=0 -> blank=0 first at cycle 3; idx sequence 0,1,...,7,0 with 10 cycles per slot; frame high exactly one cycle when idx goes 7->0; {A,B,C}=3'b110 while idx=1.
REQ-037 Reset, then en=1, dir=1 -> idx sequence 0,7,6,...; frame pulses on the 0->7 transition.
REQ-038 mode=1 with step held high for 5 cycles -> exactly one advance; no further advance during 100 idle cycles.
REQ-039 en dropped at cycle 5 of a slot -> blank=1 next cycle, idx unchanged; en re-raised -> BLANK cycles of blank=1, then the same idx is shown.
REQ-040 NDIG=3, dir=0 -> idx 0,1,2,0; frame period 30 cycles.
REQ-041 rst_n pulsed low mid-SHOW -> immediately blank=1, idx=0, {A,B,C}=3'b111, frame=0; checker asserts blank=1 on every cycle in which idx changes.
